// File: rtl/bsg_dff_en_pipe.sv
// Elastic, enable-gated register pipeline: stages_p stages of width_p bits, each with its own valid.
// Optional held-word counter on occupancy_o when BSG_DFF_EN_PIPE_OCCUPANCY_EN is defined.
module bsg_dff_en_pipe #(
  parameter int width_p  = 16,
  parameter int stages_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  input  logic               flush_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
`ifdef BSG_DFF_EN_PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(stages_p+1)-1:0] occupancy_o
`endif
);

  logic [stages_p-1:0]              valid_r;
  logic [stages_p-1:0][width_p-1:0] data_r;
  logic [stages_p-1:0]              adv;
  logic [stages_p-1:0]              src_v;
  logic [stages_p-1:0][width_p-1:0] src_data;
  logic                             in_fire;
  logic                             out_fire;

  // Advance ripples from the output back to the input, so a single ready_i
  // frees every stage behind a full run of valid words in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    adv = '0;
    adv[stages_p-1] = ~valid_r[stages_p-1] | ready_i;
    for (int k = stages_p - 2; k >= 0; k--) begin
      adv[k] = ~valid_r[k] | adv[k+1];
    end
  end

  assign ready_o  = adv[0] & ~flush_i;
  assign in_fire  = v_i & ready_o;
  assign v_o      = valid_r[stages_p-1];
  assign data_o   = data_r[stages_p-1];
  assign out_fire = v_o & ready_i;

  generate
    if (stages_p == 1) begin : g_src_single
      assign src_v    = in_fire;
      assign src_data = data_i;
    end else begin : g_src_chain
      assign src_v    = {valid_r[stages_p-2:0], in_fire};
      assign src_data = {data_r[stages_p-2:0], data_i};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_r <= '0;
    end else begin
      for (int k = 0; k < stages_p; k++) begin
        // NOTE: sequential state uses non-blocking assignment so every stage samples pre-edge values.
        if (flush_i)     valid_r[k] <= 1'b0;
        else if (adv[k]) valid_r[k] <= src_v[k];
      end
    end
  end

  // Data only captures when a valid word actually lands, so bubbles and
  // flushes leave the held value (and the clock-enable profile) untouched.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: the data array is reset on purpose: data_o must read zero while in reset.
      data_r <= '0;
    end else begin
      for (int k = 0; k < stages_p; k++) begin
        if (!flush_i && adv[k] && src_v[k]) data_r[k] <= src_data[k];
      end
    end
  end

`ifdef BSG_DFF_EN_PIPE_OCCUPANCY_EN
  localparam int occ_w = $clog2(stages_p+1);
  logic [occ_w-1:0] occ_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      occ_r <= '0;
    end else if (flush_i) begin
      occ_r <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   occ_r <= occ_r + occ_w'(1);
        2'b01:   occ_r <= occ_r - occ_w'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign occupancy_o = occ_r;
`endif

endmodule
